// File: rtl/mem_io_responder_pkg.sv
// Shared address map and read-source encoding for mem_io_responder.
package mem_io_responder_pkg;

    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [17:0] IO_UART = IO_BASE;
    localparam logic [17:0] IO_CNT  = IO_BASE + 18'h4;

    // Counter byte selects occupy 4..7 so the low two bits are the byte lane.
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_RAM  = 3'd1,
        SEL_RX   = 3'd2,
        SEL_CNT0 = 3'd4,
        SEL_CNT1 = 3'd5,
        SEL_CNT2 = 3'd6,
        SEL_CNT3 = 3'd7
    } rd_sel_e;

    function automatic logic is_io_addr(input logic [17:0] addr);
        return addr[17:16] == 2'b11;
    endfunction

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; the head byte is visible
// combinationally so it can drive a valid/ready stream directly.
module tx_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == FULL_CNT);
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];

    // A push into a full FIFO is still taken when the head leaves the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// CPU-facing memory/I-O responder: RAM pass-through, UART TX/RX ports and a
// free-running cycle counter, all read back with a fixed one-cycle latency.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        halted,
    output logic        tx_overflow
);
    localparam int               CNT_W       = $clog2(TX_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(TX_DEPTH - FULL_MARGIN);

    logic [17:0] addr;
    logic        io_sel;
    logic        unused_addr_hi;

    rd_sel_e     rd_sel_reg;
    rd_sel_e     rd_sel_next;
    logic [7:0]  rx_byte_reg;
    logic [31:0] counter_reg;
    logic [31:0] snapshot_reg;
    logic [31:0] snapshot_next;
    logic        halted_reg;
    logic        halted_next;
    logic        overflow_reg;
    logic        io_full_reg;
    logic        rx_pop_req;
    logic [7:0]  snap_bytes [4];

    logic             fifo_push;
    logic [7:0]       fifo_push_data;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign addr           = cpu_a[17:0];
    assign unused_addr_hi = ^cpu_a[31:18];
    assign io_sel         = is_io_addr(addr);

    assign ram_a     = cpu_a[16:0];
    assign ram_wdata = cpu_wdata;
    assign ram_we    = cpu_wr & ~io_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_snap_byte
            assign snap_bytes[gi] = snapshot_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        rd_sel_next    = SEL_ZERO;
        snapshot_next  = snapshot_reg;
        halted_next    = halted_reg;
        fifo_push      = 1'b0;
        fifo_push_data = cpu_wdata;
        rx_pop_req     = 1'b0;
        if (!io_sel) begin
            if (!cpu_wr) begin
                rd_sel_next = SEL_RAM;
            end
        end else if (cpu_wr) begin
            if (addr == IO_UART) begin
                fifo_push = (cpu_wdata != 8'h00);
            end else if (addr == IO_CNT) begin
                // Halt marker: a zero byte tells the host the program is done.
                fifo_push      = 1'b1;
                fifo_push_data = 8'h00;
                halted_next    = 1'b1;
            end
        end else if (addr == IO_UART) begin
            if (rx_valid) begin
                rx_pop_req  = 1'b1;
                rd_sel_next = SEL_RX;
            end
        end else if (addr[17:2] == IO_CNT[17:2]) begin
            // Only the low-byte read refreshes the snapshot, so the upper
            // bytes read afterwards belong to the same counter value.
            rd_sel_next = rd_sel_e'({1'b1, addr[1:0]});
            if (addr[1:0] == 2'b00) begin
                snapshot_next = counter_reg;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_sel_reg   <= SEL_ZERO;
            rx_byte_reg  <= '0;
            counter_reg  <= '0;
            snapshot_reg <= '0;
            halted_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            io_full_reg  <= 1'b0;
        end else begin
            rd_sel_reg   <= rd_sel_next;
            counter_reg  <= counter_reg + 32'd1;
            snapshot_reg <= snapshot_next;
            halted_reg   <= halted_next;
            overflow_reg <= overflow_reg | (fifo_push & fifo_full & ~fifo_pop);
            io_full_reg  <= (fifo_count >= FULL_THRESH);
            if (rx_pop_req) begin
                rx_byte_reg <= rx_data;
            end
        end
    end

    always_comb begin
        cpu_rdata = 8'h00;
        case (rd_sel_reg)
            SEL_RAM:                               cpu_rdata = ram_rdata;
            SEL_RX:                                cpu_rdata = rx_byte_reg;
            SEL_CNT0, SEL_CNT1, SEL_CNT2, SEL_CNT3: cpu_rdata = snap_bytes[rd_sel_reg[1:0]];
            default:                               cpu_rdata = 8'h00;
        endcase
    end

    assign rx_pop         = rx_pop_req & ~rst_in;
    assign fifo_pop       = tx_valid & tx_ready;
    assign halted         = halted_reg;
    assign tx_overflow    = overflow_reg;
    assign io_buffer_full = io_full_reg;

    tx_byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid = ~fifo_empty;

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter TX_DEPTH, default 8 (power of 2, >=4); depth of the UART transmit FIFO.
REQ-002 Parameter FULL_MARGIN, default 2; free FIFO slots remaining when io_buffer_full asserts.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-high.
REQ-005 cpu_a  input  32  CPU byte address; only [17:0] decoded.
REQ-006 cpu_wr  input  1  1 = write this cycle, 0 = read this cycle.
REQ-007 cpu_wdata  input  8  CPU write byte.
REQ-008 cpu_rdata  output  8  read byte returned to CPU one cycle after the read address.
REQ-009 io_buffer_full  output  1  tells the CPU to stop issuing I/O writes.
REQ-010 ram_a  output  17  RAM byte address; ram_we output 1; ram_wdata output 8; ram_rdata input 8 (synchronous RAM, 1-cycle read).
REQ-011 tx_data  output  8; tx_valid output 1; tx_ready input 1: valid/ready byte stream to UART transmitter.
REQ-012 rx_data  input  8; rx_valid input 1; rx_pop output 1: UART receive byte, consumed when rx_pop=1.
REQ-013 halted  output  1; tx_overflow  output  1: sticky status flags.

Function
REQ-014 Address decode: cpu_a[17:16]==2'b11 selects I/O; otherwise RAM.
REQ-015 RAM select: ram_a=cpu_a[16:0], ram_wdata=cpu_wdata, ram_we=cpu_wr, combinational pass-through.
REQ-016 I/O select: ram_we=0.
REQ-017 Read latency exactly 1 cycle: source select (RAM, RX, CNT byte k, zero) registered at cycle N; cpu_rdata valid in cycle N+1.
REQ-018 Read 0x30000: if rx_valid, rx_pop=1 same cycle and byte returns next cycle; else returns 0x00, no pop.
REQ-019 Write 0x30000 with data!=0x00 pushes data into TX FIFO; data 0x00 ignored.
REQ-020 Write 0x30004: pushes 0x00 into TX FIFO and sets halted=1.
REQ-021 Cycle counter: 32-bit, +1 every cycle from reset, wraps 0xFFFFFFFF->0.
REQ-022 Read 0x30004 captures counter snapshot and returns byte[7:0]; reads 0x30005/6/7 return snapshot bytes [15:8]/[23:16]/[31:24].
REQ-023 Reads of other I/O addresses return 0x00; writes to other I/O addresses have no effect.
REQ-024 TX FIFO: tx_valid=!empty, tx_data=head byte; pop on tx_valid&tx_ready.
REQ-025 Simultaneous push and pop when full: both performed, count unchanged.
REQ-026 Push when full and no pop: byte dropped, tx_overflow set sticky.
REQ-027 io_buffer_full=1 when count >= TX_DEPTH-FULL_MARGIN, registered from count (1-cycle lag covered by margin).
REQ-028 After halted=1, further 0x30000 writes still accepted; FIFO continues draining.
REQ-029 Pointers wrap modulo TX_DEPTH; count width log2(TX_DEPTH)+1.

Reset
REQ-030 On rst_in: cpu_rdata=0, FIFO empty (tx_valid=0), io_buffer_full=0, halted=0, tx_overflow=0, counter=0, snapshot=0, read select=zero, rx_pop=0.
REQ-031 Reset mid-operation discards FIFO contents and any in-flight read; first cycle after deassert behaves as fresh start.

Structure
REQ-032 Address constants (IO_BASE 0x30000, IO_UART, IO_CNT) and read-select encoding live in the shared const package.
REQ-033 One sub-module, tx_byte_fifo (parameterised depth, push/pop/full/empty/count); rest inline.

Verification
REQ-034 Write 0x41 to 0x30000, tx_ready=1 -> tx_valid next cycle with tx_data=0x41, popped; write 0x00 to 0x30000 -> no push.
REQ-035 RAM write 0x5A @0x00123 then read 0x00123 -> ram_we=1 then cpu_rdata=0x5A one cycle after read.
REQ-036 tx_ready=0, 6 pushes (depth 8) -> io_buffer_full=1; 9 pushes -> tx_overflow=1, FIFO holds first 8 bytes in order.
REQ-037 After 100 cycles read 0x30004..0x30007 consecutively -> bytes of snapshot 100 (+/- fixed offset), consistent despite counter advance.
REQ-038 rx_valid=1, rx_data=0x33, read 0x30000 -> rx_pop=1 same cycle, cpu_rdata=0x33 next; rx_valid=0 -> 0x00.
REQ-039 Write 0x30004 -> halted=1, 0x00 emitted on tx; assert rst_in mid-stream -> all outputs at REQ-030 values immediately.
